tty_tx_sequencer: RTL and testbench
===================================

Name: tty_tx_sequencer

Overview:
- Serial transmit controller for the teletype interface. It turns the 16x baud tick from the variable-clock divider into a framed asynchronous character on the TXD line: start bit, 8 data bits (LSB first), then stop bits.
- Provides the PDP-8 style load/busy/flag handshake to the IOT logic and owns all bit timing. The divider only supplies ticks.

Parameters:
- STOP_BITS, 2, number of stop bits per frame (legal values 1 or 2; ASR-33 uses 2).
- TICKS_PER_BIT, 16, tick strobes per bit period (power of two, 4..16).

Ports:
- clk  input  1  system clock (100 MHz).
- rst  input  1  asynchronous reset, active-high.
- tick  input  1  one-clk-wide strobe at 16x baud rate, from the baud divider.
- load  input  1  one-clk strobe requesting transmission of data.
- data  input  8  character to send; sampled only in the cycle load is accepted.
- flag_clr  input  1  one-clk strobe that clears flag and overrun.
- txd  output  1  serial line; mark = 1.
- busy  output  1  high while a frame is in progress.
- flag  output  1  sticky "transmitter done" flag.
- overrun  output  1  sticky; set when load arrives while busy.

Behaviour:
- Reset (async, active-high): state IDLE, txd=1, busy=0, flag=0, overrun=0, tick counter=0, bit counter=0, shift register=0.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE:
  - txd=1.
  - load=1: latch data into the shift register, clear tick counter, go to START, busy=1 on the next edge.
  - flag is not cleared by load. Only flag_clr clears it.
- Bit timing, all non-IDLE states:
  - Tick counter (width log2(TICKS_PER_BIT)) increments on each tick.
  - On a tick with counter == TICKS_PER_BIT-1, the current bit ends: counter wraps to 0 and the FSM advances.
  - Ticks are ignored in IDLE.
  - The start bit therefore lasts exactly TICKS_PER_BIT ticks, measured from the first tick after load. Every other bit is exactly TICKS_PER_BIT ticks.
- START: txd=0. At bit end go to DATA with bit counter=0.
- DATA:
  - txd = shift register bit 0.
  - At bit end, shift right by one and increment the bit counter.
  - After bit 7 ends, go to PARITY if that feature is enabled, otherwise STOP with stop counter=0.
- STOP:
  - txd=1.
  - At the end of each stop bit increment the stop counter. After STOP_BITS stop bits, go to IDLE.
  - On that same edge: busy=0, flag=1.
- txd is registered and changes only on clk edges coinciding with state/bit transitions.
- load while busy:
  - Frame and shift register are unaffected.
  - overrun=1 on the next edge.
- load in the same cycle the frame completes (FSM leaving STOP): treated as busy, so overrun=1 and the character is dropped.
- flag_clr:
  - Clears flag and overrun on the next edge.
  - If flag_clr coincides with the frame-complete edge, set wins: flag=1.
  - If flag_clr coincides with an overrun-causing load, overrun=1.
- No tick input during a frame: the FSM holds its state indefinitely. There is no timeout.
- rst mid-frame: immediate return to reset values, with txd=1 (the line goes to mark asynchronously).
- Frame length in ticks = TICKS_PER_BIT × (1 + 8 + P + STOP_BITS), where P = 1 if parity is enabled, else 0.

Optional Feature:
- Macro: TTY_TX_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA. It lasts one bit period with txd = even parity (XOR) of the 8 latched data bits.
  - The parity value is computed at load time and stored in a register.
- Undefined:
  - No PARITY state and no parity register.
  - DATA goes directly to STOP.

Test Plan:
- Reset: assert rst for 3 clk cycles, then release -> txd=1, busy=0, flag=0, overrun=0. No change with ticks and no load for 100 ticks.
- Frame: tick every 4 clk cycles, load data=0x55, STOP_BITS=2, no parity -> txd sequence per 16-tick bit is 0,1,0,1,0,1,0,1,0,1,1. busy falls and flag rises exactly 176 ticks after the first post-load tick.
- Overrun: load 0xA3, then load 0xFF 50 ticks later -> transmitted bits match 0xA3 (LSB first 1,1,0,0,0,1,0,1), overrun=1. A flag_clr pulse afterwards returns overrun=0 and flag=0.
- Simultaneous: assert flag_clr in the frame-complete cycle -> flag=1 afterwards. A second flag_clr -> flag=0.
- Async reset mid-frame: load 0x00, assert rst during data bit 3 -> txd=1 and busy=0 immediately (before the next clk edge). A new load 0x0F afterwards transmits a clean full frame.
- Parity (TTY_TX_PARITY_EN defined): load 0x07 -> parity bit 1 after bit 7. Load 0x03 -> parity bit 0. Frame length 192 ticks with STOP_BITS=2.

Source files
------------

// File: rtl/tty_tx_sequencer_if.sv
// tty_tx_sequencer_if: load/busy/flag handshake and serial line between the
// IOT logic (master) and the teletype transmit sequencer (slave).
interface tty_tx_sequencer_if;
    logic       tick;
    logic       load;
    logic [7:0] data;
    logic       flag_clr;
    logic       txd;
    logic       busy;
    logic       flag;
    logic       overrun;

    modport master (
        output tick, load, data, flag_clr,
        input  txd, busy, flag, overrun
    );

    modport slave (
        input  tick, load, data, flag_clr,
        output txd, busy, flag, overrun
    );
endinterface

// File: rtl/tty_tx_sequencer.sv
// tty_tx_sequencer: frames one character per load onto TXD as
// start bit, 8 data bits LSB first, optional even-parity bit, STOP_BITS stop bits.
// All bit timing is derived here from the 16x baud tick; the divider only ticks.
// Optional feature: define TTY_TX_PARITY_EN to insert the parity bit after DATA.
//
// state  | meaning
// IDLE   | line at mark, waiting for load
// START  | start bit (space)
// DATA   | shifting out the 8 data bits, LSB first
// PARITY | even parity of the latched character (TTY_TX_PARITY_EN only)
// STOP   | stop bits (mark); frame completes at the end of the last one
module tty_tx_sequencer #(
    parameter int STOP_BITS     = 2,
    parameter int TICKS_PER_BIT = 16
) (
    input  logic               clk,
    input  logic               rst,
    tty_tx_sequencer_if.slave  bus
);

    localparam int CW = $clog2(TICKS_PER_BIT);

`ifdef TTY_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
    } state_t;
`endif

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_tick_cnt;
    logic [2:0]      r_bit_cnt;
    logic [1:0]      r_stop_cnt;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_next;
    logic            r_txd;
    logic            w_txd_next;
    logic            r_busy;
    logic            w_busy_next;
    logic            r_flag;
    logic            r_overrun;
`ifdef TTY_TX_PARITY_EN
    logic            r_parity;
`endif

    logic            w_bit_end;
    logic            w_accept;
    logic            w_overrun_load;
    logic            w_frame_done;

    // A bit period ends on the tick that would wrap the tick counter; ticks are ignored in IDLE.
    assign w_bit_end      = bus.tick && (r_state != S_IDLE)
                            && (r_tick_cnt == CW'(TICKS_PER_BIT - 1));
    assign w_accept       = bus.load && (r_state == S_IDLE);
    // The frame-complete cycle is still STOP, so a load there counts as an overrun and is dropped.
    assign w_overrun_load = bus.load && (r_state != S_IDLE);
    assign w_frame_done   = w_bit_end && (r_state == S_STOP)
                            && (r_stop_cnt == 2'(STOP_BITS - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: advance only at bit boundaries (or on load from IDLE).
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.load) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end && (r_bit_cnt == 3'd7)) begin
`ifdef TTY_TX_PARITY_EN
                    w_state_next = S_PARITY;
`else
                    w_state_next = S_STOP;
`endif
                end
            end
`ifdef TTY_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_frame_done) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered line and busy, derived from the next state
    // so txd only moves on the edge where the state or bit changes.
    always_comb begin
        w_shift_next = r_shift;
        if (w_accept) begin
            w_shift_next = bus.data;
        end else if ((r_state == S_DATA) && w_bit_end) begin
            w_shift_next = {1'b0, r_shift[7:1]};
        end

        w_txd_next = 1'b1;
        case (w_state_next)
            S_START:  w_txd_next = 1'b0;
            S_DATA:   w_txd_next = w_shift_next[0];
`ifdef TTY_TX_PARITY_EN
            S_PARITY: w_txd_next = r_parity;
`endif
            default:  w_txd_next = 1'b1;
        endcase

        w_busy_next = (w_state_next != S_IDLE);
    end

    // Registered line outputs; reset drives the line to mark asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_txd  <= 1'b1;
            r_busy <= 1'b0;
        end else begin
            r_txd  <= w_txd_next;
            r_busy <= w_busy_next;
        end
    end

    // Tick counter: restarts on load so the start bit spans exactly TICKS_PER_BIT ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_accept) begin
            r_tick_cnt <= '0;
        end else if (w_bit_end) begin
            r_tick_cnt <= '0;
        end else if (bus.tick && (r_state != S_IDLE)) begin
            r_tick_cnt <= r_tick_cnt + CW'(1);
        end
    end

    // Bit and stop counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt  <= 3'd0;
            r_stop_cnt <= 2'd0;
        end else begin
            if ((r_state == S_START) && w_bit_end) begin
                r_bit_cnt <= 3'd0;
            end else if ((r_state == S_DATA) && w_bit_end) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if ((w_state_next == S_STOP) && (r_state != S_STOP)) begin
                r_stop_cnt <= 2'd0;
            end else if ((r_state == S_STOP) && w_bit_end) begin
                r_stop_cnt <= r_stop_cnt + 2'd1;
            end
        end
    end

    // Shift register: loaded only when a character is accepted in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= 8'd0;
        end else begin
            r_shift <= w_shift_next;
        end
    end

`ifdef TTY_TX_PARITY_EN
    // Even parity is captured with the character so later shifting cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^bus.data;
        end
    end
`endif

    // Sticky status: a set event on the same edge as flag_clr wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flag    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_frame_done) begin
                r_flag <= 1'b1;
            end else if (bus.flag_clr) begin
                r_flag <= 1'b0;
            end

            if (w_overrun_load) begin
                r_overrun <= 1'b1;
            end else if (bus.flag_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.txd     = r_txd;
    assign bus.busy    = r_busy;
    assign bus.flag    = r_flag;
    assign bus.overrun = r_overrun;

endmodule

// File: tb/tb_tty_tx_sequencer.sv
// tb_tty_tx_sequencer: randomized frames checked against a bit-list model of
// the frame (start, data LSB first, optional parity, stop bits).
module tb_tty_tx_sequencer;

    localparam int TPB = 16;
    localparam int SB  = 2;
`ifdef TTY_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   m_flag;
    bit   m_overrun;

    tty_tx_sequencer_if bus();

    tty_tx_sequencer #(.STOP_BITS(SB), .TICKS_PER_BIT(TPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Caller is at a negedge; tick period is gap+1 clocks. Returns at a negedge after the edge.
    task automatic do_tick(input int gap, input bit clr, input bit ld, input logic [7:0] ld_data);
        repeat (gap) @(negedge clk);
        bus.tick     = 1'b1;
        bus.flag_clr = clr;
        bus.load     = ld;
        if (ld) bus.data = ld_data;
        @(negedge clk);
        bus.tick     = 1'b0;
        bus.flag_clr = 1'b0;
        bus.load     = 1'b0;
    endtask

    task automatic pulse_load(input logic [7:0] d);
        bus.load = 1'b1;
        bus.data = d;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.flag_clr = 1'b1;
        @(negedge clk);
        bus.flag_clr = 1'b0;
        m_flag    = 1'b0;
        m_overrun = 1'b0;
    endtask

    task automatic check_status(input string tag);
        n_tests++;
        if (bus.flag !== m_flag) begin
            n_fail++;
            $display("FAIL %s flag: got %b want %b", tag, bus.flag, m_flag);
        end
        n_tests++;
        if (bus.overrun !== m_overrun) begin
            n_fail++;
            $display("FAIL %s overrun: got %b want %b", tag, bus.overrun, m_overrun);
        end
    endtask

    // One complete frame. ovr_tick>0 injects a busy load just before that tick;
    // clr_end/load_end put flag_clr/load on the frame-complete tick.
    task automatic frame(input logic [7:0] d, input int gap_lo, input int gap_hi,
                         input int ovr_tick, input bit clr_end, input bit load_end,
                         input string tag);
        bit exp_bits[$];
        int total;
        bit exp_txd;
        bit exp_busy;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
        if (P == 1) exp_bits.push_back(^d);
        for (int i = 0; i < SB; i++) exp_bits.push_back(1'b1);
        total = exp_bits.size() * TPB;

        pulse_load(d);
        n_tests++;
        if (bus.busy !== 1'b1 || bus.txd !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start: got busy=%b txd=%b want busy=1 txd=0", tag, bus.busy, bus.txd);
        end

        for (int k = 1; k <= total; k++) begin
            if (k == ovr_tick) begin
                pulse_load(8'hFF);
                m_overrun = 1'b1;
            end
            do_tick($urandom_range(gap_hi, gap_lo), clr_end && (k == total),
                    load_end && (k == total), 8'h5A);
            if (k < total) begin
                exp_txd  = exp_bits[k / TPB];
                exp_busy = 1'b1;
            end else begin
                exp_txd  = 1'b1;
                exp_busy = 1'b0;
            end
            n_tests++;
            if (bus.txd !== exp_txd || bus.busy !== exp_busy) begin
                n_fail++;
                $display("FAIL %s tick %0d of %0d: got txd=%b busy=%b want txd=%b busy=%b",
                         tag, k, total, bus.txd, bus.busy, exp_txd, exp_busy);
            end
        end

        m_flag = 1'b1;
        if (load_end) m_overrun = 1'b1;
        else if (clr_end) m_overrun = 1'b0;
        check_status(tag);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_flag    = 1'b0;
        m_overrun = 1'b0;
        n_tests++;
        if (bus.txd !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset line: got txd=%b busy=%b want txd=1 busy=0", bus.txd, bus.busy);
        end
        check_status("reset");
        for (int k = 0; k < 100; k++) begin
            do_tick($urandom_range(2, 0), 1'b0, 1'b0, 8'h00);
            n_tests++;
            if (bus.txd !== 1'b1 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_ticks %0d: got txd=%b busy=%b want txd=1 busy=0",
                         k, bus.txd, bus.busy);
            end
        end
        check_status("idle_ticks");
    endtask

    task automatic test_frame();
        frame(8'h55, 3, 3, -1, 1'b0, 1'b0, "frame55");
        pulse_clr();
        check_status("frame55_clr");
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 5; n++) begin
            frame(8'($urandom), 0, 2, -1, 1'b0, 1'b0, "random");
            pulse_clr();
            check_status("random_clr");
        end
    endtask

    task automatic test_overrun();
        frame(8'hA3, 0, 1, 50, 1'b0, 1'b0, "overrun");
        pulse_clr();
        check_status("overrun_clr");
    endtask

    task automatic test_simultaneous();
        frame(8'($urandom), 0, 1, -1, 1'b1, 1'b0, "sim_clr");
        pulse_clr();
        check_status("sim_clr2");
        frame(8'($urandom), 0, 1, -1, 1'b0, 1'b1, "sim_load");
        for (int k = 0; k < 2 * TPB; k++) begin
            do_tick(0, 1'b0, 1'b0, 8'h00);
            n_tests++;
            if (bus.txd !== 1'b1 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL dropped_load %0d: got txd=%b busy=%b want txd=1 busy=0",
                         k, bus.txd, bus.busy);
            end
        end
        pulse_clr();
        check_status("sim_load_clr");
    endtask

    task automatic test_async_reset();
        pulse_load(8'h00);
        for (int k = 0; k < 4 * TPB + TPB / 2; k++) do_tick(1, 1'b0, 1'b0, 8'h00);
        n_tests++;
        if (bus.txd !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_frame: got txd=%b busy=%b want txd=0 busy=1", bus.txd, bus.busy);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (bus.txd !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got txd=%b busy=%b want txd=1 busy=0", bus.txd, bus.busy);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_flag    = 1'b0;
        m_overrun = 1'b0;
        check_status("after_reset");
        frame(8'h0F, 0, 2, -1, 1'b0, 1'b0, "post_reset");
        pulse_clr();
    endtask

`ifdef TTY_TX_PARITY_EN
    task automatic test_parity();
        frame(8'h07, 0, 1, -1, 1'b0, 1'b0, "parity07");
        pulse_clr();
        frame(8'h03, 0, 1, -1, 1'b0, 1'b0, "parity03");
        pulse_clr();
    endtask
`endif

    initial begin
        rst          = 1'b1;
        bus.tick     = 1'b0;
        bus.load     = 1'b0;
        bus.data     = 8'h00;
        bus.flag_clr = 1'b0;
        @(negedge clk);
        test_reset();
        test_frame();
        test_random_frames();
        test_overrun();
        test_simultaneous();
        test_async_reset();
`ifdef TTY_TX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
